// File: rtl/reg_file_ops.sv
// Register bank with two combinational read ports and one operate/write port.
// Single-cycle load/inc/dec/clr; shift/rotate runs one bit per cycle under a small FSM.
module reg_file_ops #(
  parameter  int BITS  = 8,
  parameter  int NREGS = 4,
  parameter  int AMTW  = 3,
  localparam int SELW  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [2:0]      i_op,
  input  logic [SELW-1:0] i_wsel,
  input  logic [BITS-1:0] i_data,
  input  logic [AMTW-1:0] i_amt,
  input  logic [SELW-1:0] i_asel,
  input  logic [SELW-1:0] i_bsel,
  output logic [BITS-1:0] o_a,
  output logic [BITS-1:0] o_b,
  output logic            o_carry,
  output logic            o_zero,
  output logic            o_busy
);
  localparam logic [2:0] OP_LOAD = 3'b001, OP_INC = 3'b010, OP_DEC = 3'b011,
                         OP_CLR  = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110,
                         OP_ROL  = 3'b111;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  logic [NREGS-1:0][BITS-1:0] regs_q, regs_d;
  logic                       carry_q, carry_d;
  logic                       zero_q, zero_d;
  state_e                     state_q, state_d;
  logic [1:0]                 sop_q, sop_d;
  logic [SELW-1:0]            tgt_q, tgt_d;
  logic [AMTW-1:0]            cnt_q, cnt_d;

  logic [BITS-1:0]            wcur;
  logic [BITS:0]              sh;

  function automatic logic sel_ok(input logic [SELW-1:0] s);
    return {1'b0, s} < (SELW+1)'(NREGS);
  endfunction

  function automatic logic [BITS-1:0] rd(input logic [SELW-1:0] s,
                                         input logic [NREGS-1:0][BITS-1:0] r);
    return sel_ok(s) ? r[s] : '0;
  endfunction

  // One shift step; result is {carry_out, new_value}. sop uses i_op[1:0].
  function automatic logic [BITS:0] shift1(input logic [1:0] op, input logic [BITS-1:0] v);
    case (op)
      2'b01:   return {v[BITS-1], v[BITS-2:0], 1'b0};
      2'b10:   return {v[0], 1'b0, v[BITS-1:1]};
      default: return {v[BITS-1], v[BITS-2:0], v[BITS-1]};
    endcase
  endfunction

  assign wcur = rd(i_wsel, regs_q);
  assign sh   = shift1(sop_q, regs_q[tgt_q]);

  always_comb begin
    regs_d  = regs_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    state_d = state_q;
    sop_d   = sop_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sel_ok(i_wsel)) begin
          case (i_op)
            OP_LOAD: begin
              regs_d[i_wsel] = i_data;
              zero_d         = (i_data == '0);
            end
            OP_INC: begin
              {carry_d, regs_d[i_wsel]} = {1'b0, wcur} + (BITS+1)'(1);
              zero_d                    = (wcur == '1);
            end
            OP_DEC: begin
              regs_d[i_wsel] = wcur - BITS'(1);
              carry_d        = (wcur == '0);
              zero_d         = (wcur == BITS'(1));
            end
            OP_CLR: begin
              regs_d[i_wsel] = '0;
              carry_d        = 1'b0;
              zero_d         = 1'b1;
            end
            OP_SHL, OP_SHR, OP_ROL: begin
              if (i_amt == '0) begin
                carry_d = 1'b0;
                zero_d  = (wcur == '0);
              end else begin
                // Register is untouched here; the first bit moves on the next edge.
                state_d = S_SHIFT;
                sop_d   = i_op[1:0];
                tgt_d   = i_wsel;
                cnt_d   = i_amt;
              end
            end
            default: ;
          endcase
        end
      end
      S_SHIFT: begin
        regs_d[tgt_q] = sh[BITS-1:0];
        carry_d       = sh[BITS];
        cnt_d         = cnt_q - AMTW'(1);
        if (cnt_q == AMTW'(1)) begin
          zero_d  = (sh[BITS-1:0] == '0);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regs_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      state_q <= S_IDLE;
      sop_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      state_q <= state_d;
      sop_q   <= sop_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_a     = rd(i_asel, regs_q);
  assign o_b     = rd(i_bsel, regs_q);
  assign o_carry = carry_q;
  assign o_zero  = zero_q;
  assign o_busy  = (state_q == S_SHIFT);
endmodule

// File: tb/tb_reg_file_ops.sv
// Bench for reg_file_ops: directed scenarios then random ops against a
// whole-operation arithmetic model of the register bank and flags.
module tb_reg_file_ops;
  localparam int BITS = 8, NREGS = 4, AMTW = 3, SELW = 2;
  localparam int NOP = 0, LOAD = 1, INC = 2, DEC = 3, CLR = 4, SHL = 5, SHR = 6, ROL = 7;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [2:0]      i_op;
  logic [SELW-1:0] i_wsel, i_asel, i_bsel;
  logic [BITS-1:0] i_data;
  logic [AMTW-1:0] i_amt;
  logic [BITS-1:0] o_a, o_b;
  logic            o_carry, o_zero, o_busy;

  reg_file_ops #(.BITS(BITS), .NREGS(NREGS), .AMTW(AMTW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_op(i_op), .i_wsel(i_wsel), .i_data(i_data),
    .i_amt(i_amt), .i_asel(i_asel), .i_bsel(i_bsel), .o_a(o_a), .o_b(o_b),
    .o_carry(o_carry), .o_zero(o_zero), .o_busy(o_busy));

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;
  int m[NREGS];
  int mc, mz;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m[i] = 0;
    mc = 0; mz = 0;
  endtask

  // Whole-operation reference: a shift of amt bits is computed in one step.
  task automatic model_apply(input int o, input int w, input int d, input int a);
    int v, t, r;
    v = m[w];
    case (o)
      LOAD: begin m[w] = d; mz = (d == 0); end
      INC:  begin t = v + 1; mc = t >> BITS; m[w] = t % 256; mz = (m[w] == 0); end
      DEC:  begin mc = (v == 0); m[w] = (v + 255) % 256; mz = (m[w] == 0); end
      CLR:  begin m[w] = 0; mc = 0; mz = 1; end
      SHL, SHR, ROL: begin
        if (a == 0) begin
          mc = 0; mz = (v == 0);
        end else begin
          if (o == SHL) begin
            mc = ((v << (a - 1)) >> (BITS - 1)) & 1;
            m[w] = (v << a) & 255;
          end else if (o == SHR) begin
            mc = (v >> (a - 1)) & 1;
            m[w] = v >> a;
          end else begin
            r = a % BITS;
            m[w] = ((v << r) | (v >> (BITS - r))) & 255;
            mc = m[w] & 1;
          end
          mz = (m[w] == 0);
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      i_asel = SELW'(i);
      i_bsel = SELW'((i + 1) % NREGS);
      #1;
      chk({tag, "_a"}, int'(o_a), m[i]);
      chk({tag, "_b"}, int'(o_b), m[(i + 1) % NREGS]);
    end
    chk({tag, "_carry"}, int'(o_carry), mc);
    chk({tag, "_zero"}, int'(o_zero), mz);
  endtask

  // Issue one op at the next edge; for multi-cycle shifts, watch o_busy and
  // throw junk ops at the DUT that must be ignored.
  task automatic do_op(input int o, input int w, input int d, input int a);
    int old;
    old = m[w];
    i_op = 3'(o); i_wsel = SELW'(w); i_data = BITS'(d); i_amt = AMTW'(a);
    @(posedge i_clk); #1;
    i_op = 3'(NOP);
    model_apply(o, w, d, a);
    if (o >= SHL && a > 0) begin
      for (int k = 0; k < a; k++) begin
        chk("busy_hi", int'(o_busy), 1);
        if (k == 0) begin
          i_asel = SELW'(w); #1;
          chk("shift_accept_unchanged", int'(o_a), old);
          i_op = 3'(LOAD);
        end else begin
          i_op = 3'($urandom_range(1, 7));
        end
        i_wsel = SELW'($urandom_range(0, NREGS - 1));
        i_data = BITS'($urandom);
        i_amt  = AMTW'($urandom);
        @(posedge i_clk); #1;
      end
      i_op = 3'(NOP);
    end
    chk("busy_lo", int'(o_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_op = '0; i_wsel = '0; i_data = '0; i_amt = '0; i_asel = '0; i_bsel = '0;
    model_reset();
    #1;
    chk("rst_busy", int'(o_busy), 0);
    check_all("rst");
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    do_op(LOAD, 1, 8'h5A, 0);
    i_asel = 2'd1; i_bsel = 2'd0; #1;
    chk("load_r1_a", int'(o_a), 8'h5A);
    chk("load_r1_b", int'(o_b), 8'h00);
    chk("load_zero", int'(o_zero), 0);

    do_op(LOAD, 2, 8'hFF, 0);
    do_op(INC, 2, 0, 0);
    i_asel = 2'd2; #1;
    chk("inc_wrap", int'(o_a), 8'h00);
    chk("inc_carry", int'(o_carry), 1);
    chk("inc_zero", int'(o_zero), 1);
    do_op(DEC, 2, 0, 0);
    i_asel = 2'd2; #1;
    chk("dec_wrap", int'(o_a), 8'hFF);
    chk("dec_borrow", int'(o_carry), 1);
    chk("dec_zero", int'(o_zero), 0);

    do_op(LOAD, 0, 8'h81, 0);
    do_op(SHL, 0, 0, 3);
    i_asel = 2'd0; #1;
    chk("shl3", int'(o_a), 8'h08);
    chk("shl3_carry", int'(o_carry), 0);
    do_op(LOAD, 0, 8'h81, 0);
    do_op(ROL, 0, 0, 1);
    i_asel = 2'd0; #1;
    chk("rol1", int'(o_a), 8'h03);
    chk("rol1_carry", int'(o_carry), 1);

    do_op(LOAD, 3, 8'hF0, 0);
    do_op(SHR, 3, 0, 5);
    i_asel = 2'd3; #1;
    chk("shr5_ignore_load", int'(o_a), 8'h07);
    chk("shr5_carry", int'(o_carry), 1);
    check_all("dir1");

    // Reset in the middle of a long shift
    do_op(LOAD, 2, 8'hC3, 0);
    i_op = 3'(SHL); i_wsel = 2'd2; i_amt = 3'd7;
    @(posedge i_clk); #1;
    i_op = 3'(NOP);
    chk("mid_busy", int'(o_busy), 1);
    @(posedge i_clk); #1;
    i_rst = 1'b1; #1;
    model_reset();
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_carry", int'(o_carry), 0);
    chk("async_rst_zero", int'(o_zero), 0);
    i_asel = 2'd2; #1;
    chk("async_rst_reg", int'(o_a), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    do_op(LOAD, 2, 8'h3C, 0);
    check_all("post_rst");

    do_op(SHR, 1, 0, 0);
    chk("shr0_carry", int'(o_carry), 0);
    chk("shr0_zero", int'(o_zero), 1);
    i_asel = 2'd1; i_op = 3'(LOAD); i_wsel = 2'd1; i_data = 8'h77; #1;
    chk("no_bypass", int'(o_a), 0);
    do_op(LOAD, 1, 8'h77, 0);
    check_all("dir2");

    for (int n = 0; n < 80; n++) begin
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, NREGS - 1)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
